// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the pipelined comparator.
//   cmp_mode_t  - MODE encodings (codes 6 and 7 are reserved and yield 0)
//   cmp_flags_t - per-stage accumulated {eq, lt} flags
//   cmp_final() - maps a mode and final flags onto the one-bit result
package cmp_pkg;

  typedef enum logic [2:0] {
    MODE_EQ  = 3'd0,
    MODE_NE  = 3'd1,
    MODE_ULT = 3'd2,
    MODE_UGE = 3'd3,
    MODE_SLT = 3'd4,
    MODE_SGE = 3'd5
  } cmp_mode_t;

  typedef struct packed {
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Mode travels through the pipe as raw bits so reserved codes survive
  // unchanged. Any code outside the enum falls into the default arm.
  function automatic logic cmp_final(input logic [2:0] mode,
                                     input logic       eq,
                                     input logic       lt);
    logic res;
    case (mode)
      MODE_EQ:  res = eq;
      MODE_NE:  res = !eq;
      MODE_ULT: res = lt;
      MODE_UGE: res = !lt;
      MODE_SLT: res = lt;
      MODE_SGE: res = !lt;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_stage.sv
// cmp_stage: one CHUNK-bit slice of the comparator pipeline.
//   Compares the low CHUNK bits of the incoming operands, folds the result
//   into the previous stage's {eq, lt} flags and registers everything along
//   with the operands shifted down by CHUNK. The stage holds while valid and
//   the next stage is not ready.
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   prev_valid / ready     - handshake with the previous stage
//   prev_a, prev_b         - remaining operand bits, current slice in the LSBs
//   prev_mode, prev_flags  - mode and flags accumulated so far
//   valid / next_ready     - handshake with the next stage
//   a, b, mode, flags      - registered stage contents
//   o                      - registered final result (top stage only)
module cmp_stage
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  parameter bit TOP   = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             prev_valid,
  output logic             ready,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [2:0]       prev_mode,
  input  cmp_flags_t       prev_flags,
  output logic             valid,
  input  logic             next_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       mode,
  output cmp_flags_t       flags,
  output logic             o
);

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic             signed_top;
  logic             c_eq;
  logic             c_lt;
  cmp_flags_t       comb_flags;

  assign signed_top = TOP && ((prev_mode == MODE_SLT) || (prev_mode == MODE_SGE));

  // Inverting both sign bits turns a two's-complement compare into an
  // unsigned one, so the top slice can reuse the same magnitude compare.
  always_comb begin
    slice_a          = prev_a[CHUNK-1:0];
    slice_b          = prev_b[CHUNK-1:0];
    slice_a[CHUNK-1] = slice_a[CHUNK-1] ^ signed_top;
    slice_b[CHUNK-1] = slice_b[CHUNK-1] ^ signed_top;
    c_eq             = (slice_a == slice_b);
    c_lt             = (slice_a < slice_b);
    // A higher slice decides on its own unless it is equal, in which case
    // the lower slices' verdict carries through.
    comb_flags.eq    = c_eq & prev_flags.eq;
    comb_flags.lt    = c_lt | (c_eq & prev_flags.lt);
  end

  assign ready = !valid | next_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= 1'b0;
      o     <= 1'b0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a     <= prev_a >> CHUNK;
        b     <= prev_b >> CHUNK;
        mode  <= prev_mode;
        flags <= comb_flags;
        if (TOP) begin
          o <= cmp_final(prev_mode, comb_flags.eq, comb_flags.lt);
        end
      end
    end
  end

endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined two-operand comparator with valid/ready streaming.
//   Resolves CHUNK bits per stage, LSB first, over WIDTH/CHUNK stages and
//   sustains one compare per clock. Relations: EQ, NE, ULT, UGE, SLT, SGE.
// Ports:
//   CLK, RESETN       - clock, synchronous active-low reset
//   I_VALID, I_READY  - input handshake (I_READY forced low during reset)
//   I0, I1            - operands A and B
//   MODE              - relation select, sampled with the operands
//   O_VALID, O_READY  - output handshake
//   O                 - comparison result
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       MODE,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             O
);

  localparam int STAGES = WIDTH / CHUNK;

  // Index k of each chain is the input side of stage k; index k+1 is its
  // registered output side.
  logic             valid_c [STAGES+1];
  logic             ready_c [STAGES+1];
  logic [WIDTH-1:0] a_c     [STAGES+1];
  logic [WIDTH-1:0] b_c     [STAGES+1];
  logic [2:0]       mode_c  [STAGES+1];
  cmp_flags_t       flags_c [STAGES+1];
  logic             o_c     [STAGES];

  // Seeding eq=1, lt=0 makes the first stage's combine reduce to the plain
  // slice compare.
  assign valid_c[0]      = I_VALID;
  assign a_c[0]          = I0;
  assign b_c[0]          = I1;
  assign mode_c[0]       = MODE;
  assign flags_c[0]      = '{eq: 1'b1, lt: 1'b0};
  assign ready_c[STAGES] = O_READY;

  assign I_READY = ready_c[0] & RESETN;
  assign O_VALID = valid_c[STAGES];
  assign O       = o_c[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cmp_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .TOP   (k == STAGES - 1)
    ) u_stage (
      .clk        (CLK),
      .resetn     (RESETN),
      .prev_valid (valid_c[k]),
      .ready      (ready_c[k]),
      .prev_a     (a_c[k]),
      .prev_b     (b_c[k]),
      .prev_mode  (mode_c[k]),
      .prev_flags (flags_c[k]),
      .valid      (valid_c[k+1]),
      .next_ready (ready_c[k+1]),
      .a          (a_c[k+1]),
      .b          (b_c[k+1]),
      .mode       (mode_c[k+1]),
      .flags      (flags_c[k+1]),
      .o          (o_c[k])
    );
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: scoreboard bench for cmp_pipe (WIDTH=8, CHUNK=2).
//   The driver pushes the reference result of every accepted transfer; a
//   separate monitor pops and compares whenever an output transfer occurs.
//   Inputs change 2 time units after a rising edge; all sampling happens
//   2 units before the next rising edge.
module tb_cmp_pipe;
  import cmp_pkg::*;

  localparam int WIDTH   = 8;
  localparam int CHUNK   = 2;
  localparam int STAGES  = WIDTH / CHUNK;
  localparam int LATENCY = STAGES - 1;

  logic             clk;
  logic             resetn;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [2:0]       i_mode;
  logic             o_valid;
  logic             o_ready;
  logic             o;

  typedef struct {
    logic exp_o;
    int   accept_edge;
    bit   check_lat;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       tests_run    = 0;
  int       tests_failed = 0;
  int       cycle_count  = 0;
  bit       rand_ready   = 1'b0;

  cmp_pipe #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .CLK     (clk),
    .RESETN  (resetn),
    .I_VALID (i_valid),
    .I_READY (i_ready),
    .I0      (i0),
    .I1      (i1),
    .MODE    (i_mode),
    .O_VALID (o_valid),
    .O_READY (o_ready),
    .O       (o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Reference: the relation evaluated directly on whole operands.
  function automatic logic ref_model(input logic [2:0] mode,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    case (mode)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a < b;
      3'd3:    return a >= b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cycle_count);
    end
  endtask

  task automatic waitDrive();
    @(posedge clk);
    #2;
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] mode, input bit check_lat);
    sb_item_t item;
    item.exp_o       = ref_model(mode, a, b);
    item.accept_edge = cycle_count + 1;
    item.check_lat   = check_lat;
    sb_q.push_back(item);
  endtask

  // Holds the transfer until accepted; returns 2 units before the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] mode, input bit check_lat);
    bit done;
    done = 1'b0;
    waitDrive();
    i_valid = 1'b1;
    i0      = a;
    i1      = b;
    i_mode  = mode;
    for (int t = 0; t < 200 && !done; t++) begin
      if (t > 0) waitDrive();
      #6;
      if (i_ready === 1'b1) begin
        pushExpected(a, b, mode, check_lat);
        done = 1'b1;
      end
    end
    if (!done) checkOutput("acceptTimeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    waitDrive();
    i_valid = 1'b0;
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) waitDrive();
    checkOutput("drainEmpty", sb_q.size(), 0);
  endtask

  // Monitor: compares every output transfer against the scoreboard head.
  initial begin
    sb_item_t item;
    forever begin
      @(posedge clk);
      #8;
      if (resetn === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpectedOutput", 32'(o_valid), 32'd0);
        end else begin
          item = sb_q.pop_front();
          checkOutput("result", 32'(o), 32'(item.exp_o));
          if (item.check_lat)
            checkOutput("latency", cycle_count - item.accept_edge, LATENCY);
        end
      end
    end
  end

  // Random consumer backpressure, updated before the main process drives.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [2:0]       pm;
    int               acc;

    resetn  = 1'b0;
    i_valid = 1'b1;
    i0      = 8'h5A;
    i1      = 8'h5A;
    i_mode  = 3'd0;
    o_ready = 1'b1;

    // Reset held with I_VALID asserted.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #8;
      checkOutput("resetIReady", 32'(i_ready), 32'd0);
      checkOutput("resetOValid", 32'(o_valid), 32'd0);
      checkOutput("resetO", 32'(o), 32'd0);
    end
    waitDrive();
    resetn  = 1'b1;
    i_valid = 1'b0;
    #6;
    checkOutput("releaseIReady", 32'(i_ready), 32'd1);
    checkOutput("releaseOValid", 32'(o_valid), 32'd0);

    // NE back to back.
    applyStimulus(8'h5A, 8'h5A, MODE_NE, 1'b1);
    applyStimulus(8'h5A, 8'h5B, MODE_NE, 1'b1);
    drain();

    // Signedness.
    applyStimulus(8'h7F, 8'h80, MODE_ULT, 1'b1);
    applyStimulus(8'h7F, 8'h80, MODE_SLT, 1'b1);
    applyStimulus(8'h7F, 8'h80, MODE_SGE, 1'b1);
    applyStimulus(8'h80, 8'h80, MODE_UGE, 1'b1);
    drain();

    // Reserved mode followed by EQ on identical operands.
    applyStimulus(8'h33, 8'h33, 3'd6, 1'b1);
    applyStimulus(8'h33, 8'h33, MODE_EQ, 1'b1);
    drain();

    // Backpressure: consumer stalls while the pipe fills.
    pa  = WIDTH'($urandom);
    pb  = WIDTH'($urandom);
    pm  = 3'($urandom_range(0, 7));
    acc = 0;
    waitDrive();
    for (int c = 0; c < 40 && acc < 8; c++) begin
      if (c > 0) waitDrive();
      o_ready = (c >= 6);
      i_valid = 1'b1;
      i0      = pa;
      i1      = pb;
      i_mode  = pm;
      #6;
      if (c == 5) begin
        checkOutput("fullIReady", 32'(i_ready), 32'd0);
        checkOutput("heldCount", acc, 4);
      end
      if (i_ready === 1'b1) begin
        pushExpected(pa, pb, pm, 1'b0);
        acc++;
        pa = WIDTH'($urandom);
        pb = WIDTH'($urandom);
        pm = 3'($urandom_range(0, 7));
      end
    end
    checkOutput("bpAllAccepted", acc, 8);
    drain();

    // Random stream with random consumer stalls; some equal or near-equal pairs.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      pa = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       pb = pa;
        1:       pb = pa ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: pb = WIDTH'($urandom);
      endcase
      pm = 3'($urandom_range(0, 7));
      applyStimulus(pa, pb, pm, 1'b0);
    end
    waitDrive();
    rand_ready = 1'b0;
    o_ready    = 1'b1;
    i_valid    = 1'b0;
    drain();

    // Mid-flight reset discards everything in the pipe.
    applyStimulus(8'h12, 8'h34, MODE_ULT, 1'b1);
    applyStimulus(8'h56, 8'h56, MODE_EQ, 1'b1);
    applyStimulus(8'hF0, 8'h0F, MODE_SLT, 1'b1);
    waitDrive();
    resetn  = 1'b0;
    i_valid = 1'b0;
    sb_q.delete();
    #6;
    checkOutput("midResetIReady", 32'(i_ready), 32'd0);
    waitDrive();
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) waitDrive();
      #6;
      checkOutput("postResetNoValid", 32'(o_valid), 32'd0);
    end
    applyStimulus(8'h81, 8'h01, MODE_SLT, 1'b1);
    drain();

    checkOutput("finalQueueEmpty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
